// File: rtl/smac_seq_ctrl_if.sv
// Handshake and datapath bundle shared by the operand fetch side, the smac
// sequencer and the smac datapath. The sequencer uses the slave view; the
// surrounding environment (fetch, consumer, smac) uses the master view.
interface smac_seq_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    // Job descriptor
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_precision;
    logic [1:0]        cfg_fp;
    logic              cfg_chain;
    logic [CNT_W-1:0]  cfg_len;

    // Operand beats
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_weight;

    // smac control and operands
    logic              mac_ce;
    logic              mac_sclr;
    logic [DATA_W-1:0] mac_data;
    logic [DATA_W-1:0] mac_weight;
    logic [3:0]        mac_precision;
    logic [1:0]        mac_fp;
    logic              mac_chain;
    logic [DATA_W-1:0] mac_res_n;

    // Result and status
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              cfg_err;

    modport slave (
        input  cfg_valid, cfg_precision, cfg_fp, cfg_chain, cfg_len,
        input  in_valid, in_data, in_weight,
        input  mac_res_n, res_ready,
        output cfg_ready, in_ready,
        output mac_ce, mac_sclr, mac_data, mac_weight,
        output mac_precision, mac_fp, mac_chain,
        output res_valid, res_data, busy, cfg_err
    );

    modport master (
        output cfg_valid, cfg_precision, cfg_fp, cfg_chain, cfg_len,
        output in_valid, in_data, in_weight,
        output mac_res_n, res_ready,
        input  cfg_ready, in_ready,
        input  mac_ce, mac_sclr, mac_data, mac_weight,
        input  mac_precision, mac_fp, mac_chain,
        input  res_valid, res_data, busy, cfg_err
    );
endinterface

// File: rtl/smac_seq_ctrl.sv
// Sequencer for one smac instance: takes a job descriptor, clears the MAC,
// streams the operand beats into it, drains the pipeline with zero operands
// and holds the captured result until the consumer takes it.
// The PREC_* codes mirror the precision_def.vh encodings used by the smac.
module smac_seq_ctrl #(
    parameter int         DATA_W      = 64,
    parameter int         CNT_W       = 16,
    parameter int         MAC_LATENCY = 2,
    parameter logic [3:0] PREC_INT8   = 4'h1,
    parameter logic [3:0] PREC_INT16  = 4'h2,
    parameter logic [3:0] PREC_INT32  = 4'h4,
    parameter logic [3:0] PREC_INT64  = 4'h8
) (
    input  logic           clk,
    input  logic           rst,
    smac_seq_ctrl_if.slave bus
);
    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        RESULT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
    logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [3:0]         prec_q, prec_d;
    logic [1:0]         fp_q, fp_d;
    logic               chain_q, chain_d;
    logic [DATA_W-1:0]  resData_q, resData_d;
    logic               cfgErr_q, cfgErr_d;

    logic isInt8, isInt16, isInt32, isInt64;
    logic precOk, fpOk, cfgLegal;

    // Descriptor legality: known precision, non-empty job, and an FP mode the
    // selected precision actually supports (fp only on INT16/INT32, bfp16 only on INT16).
    assign isInt8   = (bus.cfg_precision == PREC_INT8);
    assign isInt16  = (bus.cfg_precision == PREC_INT16);
    assign isInt32  = (bus.cfg_precision == PREC_INT32);
    assign isInt64  = (bus.cfg_precision == PREC_INT64);
    assign precOk   = isInt8 | isInt16 | isInt32 | isInt64;
    assign fpOk     = (bus.cfg_fp == 2'd0)
                    | ((bus.cfg_fp == 2'd1) & (isInt16 | isInt32))
                    | ((bus.cfg_fp == 2'd3) & isInt16);
    assign cfgLegal = precOk & fpOk & (bus.cfg_len != '0);

    // State and job registers; reset forces IDLE with everything cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beatCnt_q  <= '0;
            drainCnt_q <= '0;
            len_q      <= '0;
            prec_q     <= '0;
            fp_q       <= '0;
            chain_q    <= 1'b0;
            resData_q  <= '0;
            cfgErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            drainCnt_q <= drainCnt_d;
            len_q      <= len_d;
            prec_q     <= prec_d;
            fp_q       <= fp_d;
            chain_q    <= chain_d;
            resData_q  <= resData_d;
            cfgErr_q   <= cfgErr_d;
        end
    end

    // Next-state logic: walks IDLE->CLEAR->RUN->DRAIN->RESULT, counting beats and drain cycles.
    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        drainCnt_d = drainCnt_q;
        len_d      = len_q;
        prec_d     = prec_q;
        fp_d       = fp_q;
        chain_d    = chain_q;
        resData_d  = resData_q;
        cfgErr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (cfgLegal) begin
                        len_d   = bus.cfg_len;
                        prec_d  = bus.cfg_precision;
                        fp_d    = bus.cfg_fp;
                        chain_d = bus.cfg_chain;
                        state_d = CLEAR;
                    end else begin
                        cfgErr_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                beatCnt_d = len_q;
                state_d   = RUN;
            end
            RUN: begin
                if (bus.in_valid) begin
                    beatCnt_d = beatCnt_q - CNT_W'(1);
                    if (beatCnt_q == CNT_W'(1)) begin
                        drainCnt_d = DRAIN_LAST;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q == '0) begin
                    resData_d = bus.mac_res_n;
                    state_d   = RESULT;
                end else begin
                    drainCnt_d = drainCnt_q - DRAIN_W'(1);
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; operands pass straight through only while running.
    always_comb begin
        bus.cfg_ready     = (state_q == IDLE) & ~rst;
        bus.in_ready      = (state_q == RUN);
        bus.mac_ce        = ((state_q == RUN) & bus.in_valid) | (state_q == DRAIN);
        bus.mac_sclr      = (state_q == CLEAR);
        bus.mac_data      = (state_q == RUN) ? bus.in_data : '0;
        bus.mac_weight    = (state_q == RUN) ? bus.in_weight : '0;
        bus.mac_precision = prec_q;
        bus.mac_fp        = fp_q;
        bus.mac_chain     = chain_q;
        bus.res_valid     = (state_q == RESULT);
        bus.res_data      = resData_q;
        bus.busy          = (state_q != IDLE);
        bus.cfg_err       = cfgErr_q;
    end
endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Bench for smac_seq_ctrl: a small accumulate-and-delay smac stand-in, a
// result scoreboard, a table of descriptors and hand-written corner sequences.
module tb_smac_seq_ctrl;
    localparam int DATA_W      = 64;
    localparam int CNT_W       = 16;
    localparam int MAC_LATENCY = 2;
    localparam logic [3:0] INT8  = 4'h1;
    localparam logic [3:0] INT16 = 4'h2;
    localparam logic [3:0] INT32 = 4'h4;
    localparam logic [3:0] INT64 = 4'h8;
    localparam logic [63:0] CAFE = 64'hcafecafecafecafe;
    localparam logic [63:0] ONES = 64'hffffffffffffffff;

    typedef struct packed {
        logic [3:0]  prec;
        logic [1:0]  fp;
        logic        chain;
        logic [15:0] len;
    } desc_t;

    typedef struct {
        desc_t d;
        bit    expErr;
        int    stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   numChecks;
    int   numErrors;
    logic [63:0] expQ[$];
    logic [3:0]  lastPrec;
    logic [1:0]  lastFp;
    logic        lastChain;
    logic [6:0]  stallPat = 7'b1011001;
    vec_t        vecs[12];

    smac_seq_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    smac_seq_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .MAC_LATENCY(MAC_LATENCY),
        .PREC_INT8(INT8), .PREC_INT16(INT16), .PREC_INT32(INT32), .PREC_INT64(INT64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // smac stand-in: stage 0 accumulates products, later stages delay it, all gated by ce.
    logic [DATA_W-1:0] smacPipe [MAC_LATENCY];
    always @(posedge clk) begin
        if (bus.mac_sclr) begin
            for (int i = 0; i < MAC_LATENCY; i++) smacPipe[i] <= '0;
        end else if (bus.mac_ce) begin
            smacPipe[0] <= smacPipe[0] + bus.mac_data * bus.mac_weight;
            for (int i = 1; i < MAC_LATENCY; i++) smacPipe[i] <= smacPipe[i-1];
        end
    end
    assign bus.mac_res_n = smacPipe[MAC_LATENCY-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Result monitor: every handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkFlag("res_unexpected", 1'b1, 1'b0);
            end else begin
                checkOutput("res_data", bus.res_data, expQ.pop_front());
            end
        end
    end

    function automatic desc_t mkDesc(input logic [3:0] p, input logic [1:0] f, input logic c, input logic [15:0] l);
        desc_t d;
        d.prec  = p;
        d.fp    = f;
        d.chain = c;
        d.len   = l;
        return d;
    endfunction

    task automatic checkAllZero(input string tag);
        $display("[TB] checking all outputs low (%s)", tag);
        checkFlag("zero_busy", bus.busy, 1'b0);
        checkFlag("zero_cfg_ready", bus.cfg_ready, 1'b0);
        checkFlag("zero_in_ready", bus.in_ready, 1'b0);
        checkFlag("zero_mac_ce", bus.mac_ce, 1'b0);
        checkFlag("zero_mac_sclr", bus.mac_sclr, 1'b0);
        checkFlag("zero_res_valid", bus.res_valid, 1'b0);
        checkFlag("zero_cfg_err", bus.cfg_err, 1'b0);
        checkOutput("zero_mac_data", bus.mac_data, 64'd0);
        checkOutput("zero_mac_weight", bus.mac_weight, 64'd0);
        checkOutput("zero_res_data", bus.res_data, 64'd0);
        checkOutput("zero_mac_cfg", 64'({bus.mac_precision, bus.mac_fp, bus.mac_chain}), 64'd0);
    endtask

    task automatic checkCfgHeld(input string name);
        checkOutput(name, 64'({bus.mac_precision, bus.mac_fp, bus.mac_chain}),
                    64'({lastPrec, lastFp, lastChain}));
    endtask

    // Presents a descriptor in IDLE (possibly already queued) and checks the CLEAR cycle.
    task automatic applyStimulus(input desc_t d);
        bus.cfg_precision = d.prec;
        bus.cfg_fp        = d.fp;
        bus.cfg_chain     = d.chain;
        bus.cfg_len       = d.len;
        bus.cfg_valid     = 1'b1;
        @(negedge clk);
        checkFlag("idle_cfg_ready", bus.cfg_ready, 1'b1);
        checkFlag("idle_busy", bus.busy, 1'b0);
        checkFlag("idle_res_valid", bus.res_valid, 1'b0);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        lastPrec  = d.prec;
        lastFp    = d.fp;
        lastChain = d.chain;
        @(negedge clk);
        checkFlag("clear_sclr", bus.mac_sclr, 1'b1);
        checkFlag("clear_ce", bus.mac_ce, 1'b0);
        checkFlag("clear_busy", bus.busy, 1'b1);
        checkFlag("clear_cfg_ready", bus.cfg_ready, 1'b0);
        checkCfgHeld("clear_cfg");
        @(posedge clk); #1;
    endtask

    // Streams n beats with an optional stall pattern; returns the sum of products.
    task automatic runBeats(input int n, input int stall, input bit useFixed,
                            input logic [63:0] fd, input logic [63:0] fw, output logic [63:0] sum);
        int accepted;
        int ceCount;
        int slot;
        logic v;
        logic [63:0] d;
        logic [63:0] w;
        accepted = 0;
        ceCount  = 0;
        slot     = 0;
        sum      = '0;
        while (accepted < n && slot < n * 8 + 16) begin
            v = (stall == 1) ? stallPat[slot % 7] : 1'b1;
            d = useFixed ? fd : {$urandom, $urandom};
            w = useFixed ? fw : {$urandom, $urandom};
            bus.in_valid  = v;
            bus.in_data   = d;
            bus.in_weight = w;
            @(negedge clk);
            checkFlag("run_in_ready", bus.in_ready, 1'b1);
            checkFlag("run_mac_ce", bus.mac_ce, v);
            checkFlag("run_sclr", bus.mac_sclr, 1'b0);
            if (v) begin
                checkOutput("run_mac_data", bus.mac_data, d);
                checkOutput("run_mac_weight", bus.mac_weight, w);
                accepted++;
                sum += d * w;
            end
            if (bus.mac_ce === 1'b1) ceCount++;
            slot++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        checkOutput("ce_beats", 64'(ceCount), 64'(n));
    endtask

    // Checks the drain cycles and the result hold; optionally queues the next descriptor.
    task automatic drainAndResult(input int hold, input bit queueNext, input desc_t nd);
        for (int i = 0; i < MAC_LATENCY; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = {$urandom, $urandom};
            bus.in_weight = {$urandom, $urandom};
            @(negedge clk);
            checkFlag("drain_ce", bus.mac_ce, 1'b1);
            checkFlag("drain_in_ready", bus.in_ready, 1'b0);
            checkFlag("drain_res_valid", bus.res_valid, 1'b0);
            checkOutput("drain_mac_data", bus.mac_data, 64'd0);
            checkOutput("drain_mac_weight", bus.mac_weight, 64'd0);
            checkCfgHeld("drain_cfg");
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (queueNext) begin
            bus.cfg_precision = nd.prec;
            bus.cfg_fp        = nd.fp;
            bus.cfg_chain     = nd.chain;
            bus.cfg_len       = nd.len;
            bus.cfg_valid     = 1'b1;
        end
        for (int k = 0; k <= hold; k++) begin
            bus.res_ready = (k == hold);
            @(negedge clk);
            checkFlag("result_valid", bus.res_valid, 1'b1);
            checkFlag("result_cfg_ready", bus.cfg_ready, 1'b0);
            checkFlag("result_ce", bus.mac_ce, 1'b0);
            checkCfgHeld("result_cfg");
            if (k < hold && expQ.size() > 0) checkOutput("result_hold", bus.res_data, expQ[0]);
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic runJob(input desc_t d, input int stall, input bit useFixed, input logic [63:0] fd,
                          input logic [63:0] fw, input int hold, input bit queueNext, input desc_t nd);
        logic [63:0] sum;
        applyStimulus(d);
        runBeats(int'(d.len), stall, useFixed, fd, fw, sum);
        expQ.push_back(sum);
        drainAndResult(hold, queueNext, nd);
    endtask

    // Rejected descriptor: one-cycle cfg_err, no state change, mac config untouched.
    task automatic applyIllegal(input desc_t d);
        bus.cfg_precision = d.prec;
        bus.cfg_fp        = d.fp;
        bus.cfg_chain     = d.chain;
        bus.cfg_len       = d.len;
        bus.cfg_valid     = 1'b1;
        @(negedge clk);
        checkFlag("bad_cfg_ready", bus.cfg_ready, 1'b1);
        checkFlag("bad_err_before", bus.cfg_err, 1'b0);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checkFlag("bad_err_pulse", bus.cfg_err, 1'b1);
        checkFlag("bad_busy", bus.busy, 1'b0);
        checkFlag("bad_sclr", bus.mac_sclr, 1'b0);
        checkCfgHeld("bad_cfg_held");
        @(posedge clk); #1;
        @(negedge clk);
        checkFlag("bad_err_end", bus.cfg_err, 1'b0);
        checkFlag("bad_busy_end", bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // Hard time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] dummy;
        desc_t none;
        numChecks = 0;
        numErrors = 0;
        lastPrec  = '0;
        lastFp    = '0;
        lastChain = 1'b0;
        none      = mkDesc(4'h0, 2'd0, 1'b0, 16'd0);
        bus.cfg_valid = 1'b0; bus.cfg_precision = '0; bus.cfg_fp = '0; bus.cfg_chain = 1'b0; bus.cfg_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_weight = '0; bus.res_ready = 1'b0;

        vecs[0]  = '{mkDesc(INT64, 2'd0, 1'b0, 16'd4), 1'b0, 0};
        vecs[1]  = '{mkDesc(4'hF,  2'd0, 1'b0, 16'd4), 1'b1, 0};
        vecs[2]  = '{mkDesc(INT8,  2'd0, 1'b0, 16'd0), 1'b1, 0};
        vecs[3]  = '{mkDesc(INT8,  2'd1, 1'b0, 16'd2), 1'b1, 0};
        vecs[4]  = '{mkDesc(INT16, 2'd2, 1'b0, 16'd2), 1'b1, 0};
        vecs[5]  = '{mkDesc(INT32, 2'd1, 1'b1, 16'd3), 1'b0, 1};
        vecs[6]  = '{mkDesc(INT32, 2'd3, 1'b0, 16'd2), 1'b1, 0};
        vecs[7]  = '{mkDesc(INT16, 2'd3, 1'b0, 16'd2), 1'b0, 0};
        vecs[8]  = '{mkDesc(INT64, 2'd1, 1'b0, 16'd2), 1'b1, 0};
        vecs[9]  = '{mkDesc(INT8,  2'd0, 1'b1, 16'd5), 1'b0, 1};
        vecs[10] = '{mkDesc(4'h3,  2'd0, 1'b0, 16'd1), 1'b1, 0};
        vecs[11] = '{mkDesc(INT16, 2'd1, 1'b1, 16'd1), 1'b0, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("power-on");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] INT64 x4, no stalls");
        runJob(mkDesc(INT64, 2'd0, 1'b0, 16'd4), 0, 1'b1, CAFE, ONES, 0, 1'b0, none);
        $display("[TB] INT64 x4, stalled in_valid");
        runJob(mkDesc(INT64, 2'd0, 1'b0, 16'd4), 1, 1'b1, CAFE, ONES, 0, 1'b0, none);

        $display("[TB] descriptor table");
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].expErr) applyIllegal(vecs[i].d);
            else runJob(vecs[i].d, vecs[i].stall, 1'b0, 64'd0, 64'd0, 0, 1'b0, none);
        end

        $display("[TB] result held 10 cycles with a queued descriptor");
        runJob(mkDesc(INT32, 2'd1, 1'b0, 16'd3), 0, 1'b0, 64'd0, 64'd0, 10, 1'b1,
               mkDesc(INT8, 2'd0, 1'b1, 16'd2));
        runJob(mkDesc(INT8, 2'd0, 1'b1, 16'd2), 0, 1'b0, 64'd0, 64'd0, 0, 1'b0, none);

        $display("[TB] BFP16 single beat");
        runJob(mkDesc(INT16, 2'd3, 1'b1, 16'd1), 0, 1'b0, 64'd0, 64'd0, 0, 1'b0, none);

        $display("[TB] reset in RUN after 3 of 8 beats");
        applyStimulus(mkDesc(INT32, 2'd0, 1'b1, 16'd8));
        runBeats(3, 0, 1'b0, 64'd0, 64'd0, dummy);
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h1234_5678_9abc_def0;
        bus.in_weight = 64'h0fed_cba9_8765_4321;
        rst = 1'b1;
        #1;
        checkAllZero("reset in RUN");
        bus.in_valid = 1'b0;
        lastPrec  = '0;
        lastFp    = '0;
        lastChain = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkFlag("post_reset_busy", bus.busy, 1'b0);
        checkFlag("post_reset_cfg_ready", bus.cfg_ready, 1'b1);
        checkCfgHeld("post_reset_cfg");
        @(posedge clk); #1;
        runJob(mkDesc(INT64, 2'd0, 1'b0, 16'd4), 0, 1'b1, CAFE, ONES, 0, 1'b0, none);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end
endmodule
